zjh_tc_accum: RTL and testbench

//  Downstream stage of the 4-bit sign-magnitude -> two's-complement converter.

---
 rtl/zjh_tc_accum.sv | 112 +++++++++++
 tb/tb_zjh_tc_accum.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/zjh_tc_accum.sv
// zjh_tc_accum: accumulates N_SAMPLES 4-bit two's-complement codes into a
// saturating signed sum, then holds the frame result until the consumer takes it.
module zjh_tc_accum #(
  parameter int ACC_W     = 8,
  parameter int N_SAMPLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [3:0]       tc_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] sum_out,
  output logic             sat_flag,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = $clog2(N_SAMPLES + 1);
  localparam logic signed [ACC_W:0] MAXV = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV = {2'b11, {(ACC_W-1){1'b0}}};
  localparam logic [CW-1:0]         LAST = CW'(N_SAMPLES - 1);

  typedef enum logic {ACC, HOLD} state_e;

  state_e                  state_q;
  logic signed [ACC_W-1:0] acc_q;
  logic                    sat_q;
  logic [CW-1:0]           cnt_q;
  logic [ACC_W-1:0]        sum_q;
  logic                    flag_q;
  logic                    ov_q;

  logic signed [ACC_W:0]   ext;
  logic signed [ACC_W:0]   t;
  logic signed [ACC_W-1:0] acc_d;
  logic                    sat_d;
  logic                    accept;

  assign in_ready  = (state_q == ACC);
  assign accept    = in_valid && in_ready;
  assign sum_out   = sum_q;
  assign sat_flag  = flag_q;
  assign out_valid = ov_q;

  // Saturating add of the incoming sample onto the running sum.
  always_comb begin
    ext   = {{(ACC_W-3){tc_in[3]}}, tc_in};
    t     = {acc_q[ACC_W-1], acc_q} + ext;
    acc_d = t[ACC_W-1:0];
    sat_d = sat_q;
    if (t > MAXV) begin
      acc_d = MAXV[ACC_W-1:0];
      sat_d = 1'b1;
    end else if (t < MINV) begin
      acc_d = MINV[ACC_W-1:0];
      sat_d = 1'b1;
    end
  end

  // Frame FSM: accumulate in ACC, present and hold the result in HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      flag_q  <= 1'b0;
      ov_q    <= 1'b0;
    end else if (clr) begin
      state_q <= ACC;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      flag_q  <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          if (accept) begin
            acc_q <= acc_d;
            sat_q <= sat_d;
            if (cnt_q == LAST) begin
              cnt_q   <= '0;
              sum_q   <= acc_d;
              flag_q  <= sat_d;
              ov_q    <= 1'b1;
              state_q <= HOLD;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        HOLD: begin
          // Release clears the running state; sum_out keeps the last frame.
          if (out_ready) begin
            acc_q   <= '0;
            sat_q   <= 1'b0;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            ov_q    <= 1'b0;
            state_q <= ACC;
          end
        end
        default: state_q <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_zjh_tc_accum.sv
// Bench for zjh_tc_accum: an 8-bit and a 5-bit instance share one stimulus stream
// and are compared against a frame-level saturating-sum model.
module tb_zjh_tc_accum;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] tc_in = '0;

  logic       ir8, ov8, sf8;
  logic [7:0] s8;
  logic       ir5, ov5, sf5;
  logic [4:0] s5;

  zjh_tc_accum #(.ACC_W(8), .N_SAMPLES(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .tc_in(tc_in), .in_valid(in_valid),
    .in_ready(ir8), .sum_out(s8), .sat_flag(sf8), .out_valid(ov8), .out_ready(out_ready)
  );

  zjh_tc_accum #(.ACC_W(5), .N_SAMPLES(8)) dut5 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .tc_in(tc_in), .in_valid(in_valid),
    .in_ready(ir5), .sum_out(s5), .sat_flag(sf5), .out_valid(ov5), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: collected samples of the current frame plus the held result.
  bit m_hold;
  int m_fs[8];
  int m_cnt;
  int m_sum8, m_sum5;
  bit m_f8, m_f5;

  typedef struct {
    logic [31:0] smp;   // sample i in bits [4*i+3:4*i]
    logic [7:0]  e8;
    logic        e8s;
    logic [4:0]  e5;
    logic        e5s;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int satfold(input int w, output bit sat);
    int mx, mn, acc, t;
    mx  = (1 << (w - 1)) - 1;
    mn  = -(1 << (w - 1));
    acc = 0;
    sat = 1'b0;
    for (int i = 0; i < 8; i++) begin
      t = acc + m_fs[i];
      if (t > mx) begin acc = mx; sat = 1'b1; end
      else if (t < mn) begin acc = mn; sat = 1'b1; end
      else acc = t;
    end
    return acc;
  endfunction

  task automatic model_reset();
    m_hold = 1'b0; m_cnt = 0; m_sum8 = 0; m_sum5 = 0; m_f8 = 1'b0; m_f5 = 1'b0;
  endtask

  task automatic model_edge(input bit c, input bit v, input int s, input bit r);
    if (c) begin
      model_reset();
    end else if (m_hold) begin
      if (r) begin
        m_hold = 1'b0; m_f8 = 1'b0; m_f5 = 1'b0; m_cnt = 0;
      end
    end else if (v) begin
      m_fs[m_cnt] = s;
      m_cnt++;
      if (m_cnt == 8) begin
        m_sum8 = satfold(8, m_f8);
        m_sum5 = satfold(5, m_f5);
        m_hold = 1'b1;
        m_cnt  = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/in_ready8"},  32'(ir8), 32'(!m_hold));
    chk({tag, "/out_valid8"}, 32'(ov8), 32'(m_hold));
    chk({tag, "/sum8"},       32'(s8),  32'(m_sum8 & 255));
    chk({tag, "/sat8"},       32'(sf8), 32'(m_f8));
    chk({tag, "/in_ready5"},  32'(ir5), 32'(!m_hold));
    chk({tag, "/out_valid5"}, 32'(ov5), 32'(m_hold));
    chk({tag, "/sum5"},       32'(s5),  32'(m_sum5 & 31));
    chk({tag, "/sat5"},       32'(sf5), 32'(m_f5));
  endtask

  task automatic step(input bit c, input bit v, input logic [3:0] s, input bit r, input string tag);
    clr = c; in_valid = v; tc_in = s; out_ready = r;
    @(posedge clk);
    model_edge(c, v, $signed(s), r);
    #1 check_all(tag);
  endtask

  initial begin
    logic [31:0] smp;
    logic [7:0]  held;

    tbl[0] = '{32'h33333333, 8'h18, 1'b0, 5'h0F, 1'b1};
    tbl[1] = '{32'h88888888, 8'hC0, 1'b0, 5'h10, 1'b1};
    tbl[2] = '{32'h77777777, 8'h38, 1'b0, 5'h0F, 1'b1};
    tbl[3] = '{32'h00008777, 8'h0D, 1'b0, 5'h07, 1'b1};
    tbl[4] = '{32'h11111111, 8'h08, 1'b0, 5'h08, 1'b0};
    tbl[5] = '{32'h22222222, 8'h10, 1'b0, 5'h0F, 1'b1};
    tbl[6] = '{32'h78787878, 8'hFC, 1'b0, 5'h1C, 1'b0};
    tbl[7] = '{32'hFFFFFFFF, 8'hF8, 1'b0, 5'h18, 1'b0};

    model_reset();
    #12 check_all("reset");
    @(negedge clk) rst_n = 1'b1;
    #1 check_all("post_reset");

    // Table of whole frames; expected sums worked out by hand.
    for (int f = 0; f < 8; f++) begin
      smp = tbl[f].smp;
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, smp[4*i +: 4], 1'b0, "frame");
      chk("tbl_ov8",  32'(ov8), 32'd1);
      chk("tbl_sum8", 32'(s8),  32'(tbl[f].e8));
      chk("tbl_sat8", 32'(sf8), 32'(tbl[f].e8s));
      chk("tbl_sum5", 32'(s5),  32'(tbl[f].e5));
      chk("tbl_sat5", 32'(sf5), 32'(tbl[f].e5s));
      step(1'b0, 1'b0, 4'h0, 1'b1, "release");
      chk("rel_keep_sum8", 32'(s8), 32'(tbl[f].e8));
    end

    // Asynchronous reset mid-frame, off the clock edge.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'h3, 1'b0, "pre_rst");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 4'h1, 1'b0, "after_rst");
    chk("after_rst_not_done", 32'(ov8), 32'd0);
    step(1'b0, 1'b1, 4'h1, 1'b0, "after_rst_last");
    chk("after_rst_sum8", 32'(s8), 32'h08);

    // Backpressure: held frame stays put while in_valid is asserted.
    held = s8;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 4'h7, 1'b0, "bp");
      chk("bp_stable", 32'(s8), 32'(held));
      chk("bp_in_ready", 32'(ir8), 32'd0);
    end
    step(1'b0, 1'b1, 4'h7, 1'b1, "bp_release");
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 4'h1, 1'b0, "bp_next");
    chk("bp_next_sum8", 32'(s8), 32'h08);
    step(1'b0, 1'b0, 4'h0, 1'b1, "release2");

    // Synchronous clear mid-frame and during HOLD.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'h5, 1'b0, "pre_clr");
    step(1'b1, 1'b1, 4'h5, 1'b0, "clr");
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 4'h2, 1'b0, "post_clr");
    chk("post_clr_sum8", 32'(s8), 32'h10);
    step(1'b1, 1'b1, 4'h3, 1'b0, "clr_hold");
    chk("clr_hold_ov8",  32'(ov8), 32'd0);
    chk("clr_hold_sum8", 32'(s8),  32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7),
           4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 4), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
